// File: rtl/rep_add_multiplier.sv
// rep_add_multiplier
//   Sequential multiplier that forms a product by repeated addition. The
//   counter, accumulator, zero detect and control FSM all sit in this block.
//   It uses a start/busy/done handshake.
//
// Parameters
//   WIDTH   operand width; product is 2*WIDTH bits
//   SIGNED  0 = unsigned operands, 1 = two's complement operands
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    request, sampled only in IDLE
//   a_in     multiplicand, captured on the accepting edge
//   b_in     multiplier, captured on the accepting edge
//   busy     high while in CALC and DONE
//   done     one-cycle pulse; product is valid from this cycle on
//   product  registered result, held until the next done
//
// Optional feature
//   REP_MULT_MIN_SWAP_EN  when defined, the smaller operand magnitude drives
//   the iteration count, which shortens latency. The product is unchanged.

module rep_add_multiplier #(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   cnt;
    logic               neg;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_in;
    logic               cnt_zero;

    // Operand magnitudes. In signed mode -2^(WIDTH-1) negates to itself,
    // which reads correctly as 2^(WIDTH-1) once treated as unsigned.
    always_comb begin
        mag_a  = a_in;
        mag_b  = b_in;
        neg_in = 1'b0;
        if (SIGNED != 0) begin
            if (a_in[WIDTH-1]) mag_a = '0 - a_in;
            if (b_in[WIDTH-1]) mag_b = '0 - b_in;
            neg_in = a_in[WIDTH-1] ^ b_in[WIDTH-1];
        end
    end

    assign cnt_zero = (cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = CALC;
            CALC:    if (cnt_zero) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            CALC:    busy = 1'b1;
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    // Datapath: operand capture, accumulation and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            addend  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        neg <= neg_in;
`ifdef REP_MULT_MIN_SWAP_EN
                        // Strict compare so a tie keeps |b| as the count.
                        if (mag_a < mag_b) begin
                            cnt    <= mag_a;
                            addend <= {{WIDTH{1'b0}}, mag_b};
                        end else begin
                            cnt    <= mag_b;
                            addend <= {{WIDTH{1'b0}}, mag_a};
                        end
`else
                        cnt    <= mag_b;
                        addend <= {{WIDTH{1'b0}}, mag_a};
`endif
                    end
                end
                CALC: begin
                    if (!cnt_zero) begin
                        acc <= acc + addend;
                        cnt <= cnt - 1'b1;
                    end else begin
                        product <= neg ? ('0 - acc) : acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rep_add_multiplier.sv
// Directed testbench for rep_add_multiplier. It runs a 16-bit unsigned
// instance and an 8-bit signed instance side by side, with a shared clock
// and reset. Latency expectations follow REP_MULT_MIN_SWAP_EN when it is
// defined.

`ifdef REP_MULT_MIN_SWAP_EN
`define LAT(plain, swapped) (swapped)
`else
`define LAT(plain, swapped) (plain)
`endif

module tb_rep_add_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        st16 = 1'b0;
    logic [15:0] a16  = '0;
    logic [15:0] b16  = '0;
    logic        busy16, done16;
    logic [31:0] prod16;

    logic        st8 = 1'b0;
    logic [7:0]  a8  = '0;
    logic [7:0]  b8  = '0;
    logic        busy8, done8;
    logic [15:0] prod8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rep_add_multiplier #(.WIDTH(16), .SIGNED(0)) u_mul16 (
        .clk     (clk),
        .rst     (rst),
        .start   (st16),
        .a_in    (a16),
        .b_in    (b16),
        .busy    (busy16),
        .done    (done16),
        .product (prod16)
    );

    rep_add_multiplier #(.WIDTH(8), .SIGNED(1)) u_mul8 (
        .clk     (clk),
        .rst     (rst),
        .start   (st8),
        .a_in    (a8),
        .b_in    (b8),
        .busy    (busy8),
        .done    (done8),
        .product (prod8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic cur_done(input bit s8);
        return s8 ? done8 : done16;
    endfunction

    function automatic logic cur_busy(input bit s8);
        return s8 ? busy8 : busy16;
    endfunction

    function automatic logic [31:0] cur_prod(input bit s8);
        return s8 ? {16'h0, prod8} : prod16;
    endfunction

    task automatic set_start(input bit s8, input logic v);
        if (s8) st8 = v;
        else    st16 = v;
    endtask

    // Called at a negedge. The task issues one start, waits for done, and
    // checks latency, product and busy release.
    task automatic run_op(input bit s8, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_p, input int exp_lat, input string tag);
        int edges;
        if (s8) begin a8 = a[7:0]; b8 = b[7:0]; end
        else    begin a16 = a;     b16 = b;     end
        set_start(s8, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(s8, 1'b0);
        check({tag, "_busy"}, 64'(cur_busy(s8)), 64'd1);
        edges = 0;
        while (!cur_done(s8) && edges < exp_lat + 20) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_done"}, 64'(cur_done(s8)), 64'd1);
        check({tag, "_lat"}, 64'(edges), 64'(exp_lat));
        check({tag, "_prod"}, 64'(cur_prod(s8)), 64'(exp_p));
        @(negedge clk);
        check({tag, "_idle"}, 64'({cur_busy(s8), cur_done(s8)}), 64'd0);
    endtask

    initial begin
        int edges;
        int last_done;
        int cyc;

        repeat (2) @(negedge clk);
        check("rst_busy16", 64'(busy16), 64'd0);
        check("rst_done16", 64'(done16), 64'd0);
        check("rst_prod16", 64'(prod16), 64'd0);
        check("rst_prod8",  64'(prod8),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned 16-bit vectors.
        run_op(1'b0, 16'd7,     16'd5, 32'd35,        `LAT(6, 6), "u7x5");
        run_op(1'b0, 16'd65535, 16'd3, 32'h0002_FFFD, `LAT(4, 4), "umaxx3");
`ifdef REP_MULT_MIN_SWAP_EN
        run_op(1'b0, 16'd3, 16'd65535, 32'h0002_FFFD, 4, "u3xmax");
`endif

        // Signed 8-bit vectors.
        run_op(1'b1, 16'h00FD, 16'h0004, 32'h0000_FFF4, `LAT(5, 4),     "sm3x4");
        run_op(1'b1, 16'h0080, 16'h0080, 32'h0000_4000, `LAT(129, 129), "smin2");
        run_op(1'b1, 16'h0005, 16'h0000, 32'h0000_0000, `LAT(1, 1),     "s5x0");

        // A start raised during CALC must be ignored. The old product stays
        // visible until the next done.
        a16 = 16'd2; b16 = 16'd10; st16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st16 = 1'b0;
        check("ign_oldprod", 64'(prod16), 64'h0002_FFFD);
        @(negedge clk);
        a16 = 16'd9; b16 = 16'd9; st16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0;
        edges = 2;
        while (!done16 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check("ign_lat",  64'(edges),  64'(`LAT(11, 3)));
        check("ign_prod", 64'(prod16), 64'd20);
        @(negedge clk);
        run_op(1'b0, 16'd9, 16'd9, 32'd81, `LAT(10, 10), "u9x9");

        // Reset while CALC is in progress.
        a16 = 16'd4; b16 = 16'd50; st16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st16 = 1'b0;
        repeat (`LAT(10, 3)) @(negedge clk);
        check("mid_busy", 64'(busy16), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_state", 64'({busy16, done16}), 64'd0);
        check("mrst_prod",  64'(prod16), 64'd0);
        run_op(1'b0, 16'd4, 16'd2, 32'd8, `LAT(3, 3), "u4x2");

        // Start held high gives back-to-back operations.
        a16 = 16'd3; b16 = 16'd2; st16 = 1'b1;
        last_done = -1;
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            edges = 0;
            @(negedge clk); cyc++;
            while (!done16 && edges < 20) begin
                @(negedge clk); cyc++; edges++;
            end
            check("b2b_done", 64'(done16), 64'd1);
            check("b2b_prod", 64'(prod16), 64'd6);
            if (last_done >= 0) check("b2b_period", 64'(cyc - last_done), 64'd5);
            last_done = cyc;
        end
        st16 = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
